// File: rtl/dyn_add_pkg.sv
// Shared types and helpers for the chunked dynamic-width adder.
package dyn_add_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   // Number of chunk_w-wide slices needed to cover x bits.
   function automatic int ceil_div(input int x, input int chunk_w);
      return (x + chunk_w - 1) / chunk_w;
   endfunction

endpackage

// File: rtl/dyn_chunk_adder_if.sv
// Handshake and data bus between the adder and its producer/consumer.
interface dyn_chunk_adder_if #(
   parameter int A_W = 8,
   parameter int B_W = 10
);
   localparam int EW = $clog2(B_W + 1);

   logic           in_valid;
   logic           in_ready;
   logic [A_W-1:0] a;
   logic [B_W-1:0] b;
   logic           out_valid;
   logic           out_ready;
   logic [B_W:0]   sum;
   logic [EW-1:0]  eff_w;
   logic           busy;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, sum, eff_w, busy
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, sum, eff_w, busy
   );

endinterface

// File: rtl/dyn_chunk_adder_chunk.sv
// Combinational CHUNK_W-bit ripple adder built from full-adder cells.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

module chunk_adder #(
   parameter int CHUNK_W = 4
) (
   input  logic [CHUNK_W-1:0] a,
   input  logic [CHUNK_W-1:0] b,
   input  logic               cin,
   output logic [CHUNK_W-1:0] sum,
   output logic               cout
);
   logic [CHUNK_W:0] carry;

   assign carry[0] = cin;

   for (genvar i = 0; i < CHUNK_W; i++) begin : g_cell
      full_adder u_fa (
         .a    (a[i]),
         .b    (b[i]),
         .cin  (carry[i]),
         .sum  (sum[i]),
         .cout (carry[i+1])
      );
   end

   assign cout = carry[CHUNK_W];
endmodule

// File: rtl/dyn_chunk_adder.sv
// Multi-cycle adder processing CHUNK_W bits per cycle over the effective operand width.
// Define DYN_ADD_EARLY_TERM_EN to stop after the chunks covering eff_w instead of all of B_W.
module dyn_chunk_adder
   import dyn_add_pkg::*;
#(
   parameter int A_W     = 8,
   parameter int B_W     = 10,
   parameter int CHUNK_W = 4
) (
   input logic            clk,
   input logic            rst_n,
   dyn_chunk_adder_if.slave bus
);
   localparam int EW    = $clog2(B_W + 1);
   localparam int N_MAX = ceil_div(B_W, CHUNK_W);
   localparam int PAD_W = N_MAX * CHUNK_W;
   localparam int KW    = $clog2(N_MAX + 1);

   state_t             state;
   logic [PAD_W-1:0]   a_pad;
   logic [PAD_W-1:0]   b_pad;
   logic [KW-1:0]      k;
   logic [KW-1:0]      n_chunks;
   logic               carry;
   logic [B_W:0]       sum_r;
   logic [EW-1:0]      eff_r;
   logic               in_ready_r;
   logic               out_valid_r;
   logic               busy_r;

   logic [EW-1:0]      lead;
   logic [EW-1:0]      eff_next;
   logic [KW-1:0]      n_next;
   logic [CHUNK_W-1:0] a_ch;
   logic [CHUNK_W-1:0] b_ch;
   logic [CHUNK_W-1:0] ch_sum;
   logic               ch_cout;

   // Leading-one detect on b; the effective width never drops below A_W.
   always_comb begin
      lead = '0;
      for (int i = 0; i < B_W; i++) begin
         if (bus.b[i]) lead = EW'(i + 1);
      end
      eff_next = (lead > EW'(A_W)) ? lead : EW'(A_W);
`ifdef DYN_ADD_EARLY_TERM_EN
      n_next = KW'(ceil_div(int'(eff_next), CHUNK_W));
`else
      n_next = KW'(N_MAX);
`endif
   end

   always_comb begin
      a_ch = '0;
      b_ch = '0;
      for (int i = 0; i < N_MAX; i++) begin
         if (k == KW'(i)) begin
            a_ch = a_pad[i*CHUNK_W +: CHUNK_W];
            b_ch = b_pad[i*CHUNK_W +: CHUNK_W];
         end
      end
   end

   chunk_adder #(.CHUNK_W(CHUNK_W)) u_chunk (
      .a    (a_ch),
      .b    (b_ch),
      .cin  (carry),
      .sum  (ch_sum),
      .cout (ch_cout)
   );

   // Carry-out lands just above the last processed chunk; padded bits beyond B_W are dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         a_pad       <= '0;
         b_pad       <= '0;
         k           <= '0;
         n_chunks    <= '0;
         carry       <= 1'b0;
         sum_r       <= '0;
         eff_r       <= '0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a_pad      <= PAD_W'(bus.a);
                  b_pad      <= PAD_W'(bus.b);
                  eff_r      <= eff_next;
                  n_chunks   <= n_next;
                  carry      <= 1'b0;
                  k          <= '0;
                  sum_r      <= '0;
                  in_ready_r <= 1'b0;
                  busy_r     <= 1'b1;
                  state      <= CALC;
               end
            end
            CALC: begin
               for (int p = 0; p <= B_W; p++) begin
                  if (k == KW'(p / CHUNK_W)) sum_r[p] <= ch_sum[p % CHUNK_W];
                  if ((p % CHUNK_W == 0) && (p > 0) && (k == KW'(p / CHUNK_W - 1)) &&
                      (n_chunks == KW'(p / CHUNK_W))) begin
                     sum_r[p] <= ch_cout;
                  end
               end
               carry <= ch_cout;
               k     <= k + KW'(1);
               if (k == n_chunks - KW'(1)) begin
                  busy_r      <= 1'b0;
                  out_valid_r <= 1'b1;
                  state       <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: begin
               state       <= IDLE;
               in_ready_r  <= 1'b1;
               out_valid_r <= 1'b0;
               busy_r      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.sum       = sum_r;
   assign bus.eff_w     = eff_r;
   assign bus.busy      = busy_r;

endmodule

// File: tb/tb_dyn_chunk_adder.sv
// Directed self-checking bench for dyn_chunk_adder (A_W=8, B_W=10, CHUNK_W=4).
// Latency expectations follow DYN_ADD_EARLY_TERM_EN if it is defined for the build.
module tb_dyn_chunk_adder;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

`ifdef DYN_ADD_EARLY_TERM_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   dyn_chunk_adder_if #(.A_W(8), .B_W(10)) bus ();

   dyn_chunk_adder #(.A_W(8), .B_W(10), .CHUNK_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // One full transaction: accept, wait for result, optional back-pressure, handshake.
   task automatic applyStimulus(input string tag, input logic [7:0] av, input logic [9:0] bv,
                                input logic [10:0] expSum, input logic [3:0] expEff,
                                input int latEarly, input int holdCycles, input bit noise);
      int lat;
      int cycles;
      lat = EARLY ? latEarly : 3;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a        = av;
      bus.b        = bv;
      @(posedge clk);
      #1;
      bus.in_valid = noise;
      bus.a        = ~av;
      bus.b        = ~bv;
      checkOutput({tag, "_in_ready_low"}, 32'(bus.in_ready), 32'd0);
      checkOutput({tag, "_busy_high"}, 32'(bus.busy), 32'd1);
      checkOutput({tag, "_sum_cleared"}, 32'(bus.sum), 32'd0);
      cycles = 0;
      while (bus.out_valid !== 1'b1 && cycles < 20) begin
         @(posedge clk);
         #1;
         cycles++;
      end
      bus.in_valid = 1'b0;
      checkOutput({tag, "_latency"}, 32'(cycles), 32'(lat));
      checkOutput({tag, "_sum"}, 32'(bus.sum), 32'(expSum));
      checkOutput({tag, "_eff_w"}, 32'(bus.eff_w), 32'(expEff));
      checkOutput({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
      checkOutput({tag, "_in_ready_done"}, 32'(bus.in_ready), 32'd0);
      for (int i = 0; i < holdCycles; i++) begin
         @(posedge clk);
         #1;
         checkOutput({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
         checkOutput({tag, "_hold_sum"}, 32'(bus.sum), 32'(expSum));
         checkOutput({tag, "_hold_eff_w"}, 32'(bus.eff_w), 32'(expEff));
         checkOutput({tag, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      checkOutput({tag, "_ready_after"}, 32'(bus.in_ready), 32'd1);
      checkOutput({tag, "_valid_after"}, 32'(bus.out_valid), 32'd0);
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.out_ready = 1'b0;
      rst_n         = 1'b0;
      #12;
      checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
      checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("rst_busy", 32'(bus.busy), 32'd0);
      checkOutput("rst_sum", 32'(bus.sum), 32'd0);
      checkOutput("rst_eff_w", 32'(bus.eff_w), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      applyStimulus("ff_0ff", 8'hFF, 10'h0FF, 11'h1FE, 4'd8,  2, 0, 1'b0);
      applyStimulus("01_3ff", 8'h01, 10'h3FF, 11'h400, 4'd10, 3, 0, 1'b1);
      applyStimulus("80_100", 8'h80, 10'h100, 11'h180, 4'd9,  3, 5, 1'b0);
      applyStimulus("zero",   8'h00, 10'h000, 11'h000, 4'd8,  2, 0, 1'b0);
      applyStimulus("ff_001", 8'hFF, 10'h001, 11'h100, 4'd8,  2, 0, 1'b0);
      applyStimulus("ff_3ff", 8'hFF, 10'h3FF, 11'h4FE, 4'd10, 3, 2, 1'b0);

      // Abort mid-calculation with an asynchronous reset pulse.
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a        = 8'hFF;
      bus.b        = 10'h3FF;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("abort_busy_before", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("abort_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("abort_busy", 32'(bus.busy), 32'd0);
      checkOutput("abort_sum", 32'(bus.sum), 32'd0);
      checkOutput("abort_eff_w", 32'(bus.eff_w), 32'd0);
      checkOutput("abort_in_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      applyStimulus("post_rst", 8'h5A, 10'h2C3, 11'h31D, 4'd10, 3, 1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dyn_chunk_adder.md
DYN_CHUNK_ADDER -- requirements
Module: dyn_chunk_adder

Interface
REQ-001 Parameter A_W, default 8: width of operand a; SHALL satisfy A_W <= B_W.
REQ-002 Parameter B_W, default 10: width of operand b; the sum width is B_W+1.
REQ-003 Parameter CHUNK_W, default 4: bits added per cycle; SHALL satisfy 1 <= CHUNK_W <= B_W.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  operands a and b are valid this cycle.
REQ-007 in_ready  output  1  block accepts operands; equals 1 exactly in IDLE.
REQ-008 a  input  A_W  unsigned operand.
REQ-009 b  input  B_W  unsigned operand; its MSB set bit defines the effective width.
REQ-010 out_valid  output  1  sum and eff_w are valid.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 sum  output  B_W+1  a+b, registered.
REQ-013 eff_w  output  $clog2(B_W+1)  effective operand width used.
REQ-014 busy  output  1  high in CALC.

Function
REQ-015 States SHALL be IDLE, CALC and DONE.
REQ-016 IDLE -> CALC on an edge with in_valid&in_ready; a and b are captured on that edge.
REQ-017 Capture SHALL latch eff_w = max(A_W, index of highest set bit of b + 1); b=0 gives A_W.
REQ-018 Capture SHALL latch n_chunks = ceil(eff_w/CHUNK_W), clear the carry register, and clear the chunk index.
REQ-019 Each CALC edge SHALL add chunk k (bits k*CHUNK_W upward, zero-padded beyond B_W), write the result into sum, update the carry, and increment k.
REQ-020 After the edge processing chunk n_chunks-1: the final carry SHALL go to bit min(n_chunks*CHUNK_W, B_W); state -> DONE.
REQ-021 out_valid SHALL be high exactly in DONE, first n_chunks cycles after the accept edge.
REQ-022 sum SHALL equal the exact a+b; all bits above eff_w SHALL be 0.
REQ-023 sum and eff_w SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 DONE -> IDLE on an edge with out_ready=1; a new accept can occur no earlier than the next edge (no overlap).
REQ-025 in_valid during CALC/DONE SHALL be ignored.
REQ-026 sum SHALL be cleared to 0 on accept.

Reset
REQ-027 While rst_n=0: state=IDLE, out_valid=0, busy=0, sum=0, eff_w=0, carry=0, k=0, and in_ready=1.
REQ-028 Reset asserted in CALC or DONE SHALL abort immediately with no result delivered; operation resumes in IDLE on the first edge after release.

Configuration
REQ-029 Macro DYN_ADD_EARLY_TERM_EN defined: n_chunks follows REQ-018, so latency depends on eff_w.
REQ-030 DYN_ADD_EARLY_TERM_EN undefined: n_chunks = ceil(B_W/CHUNK_W) for every operation; eff_w and sum values are unchanged.

Structure
REQ-031 Package dyn_add_pkg SHALL hold the state enum and a constant function computing ceil(x/CHUNK_W).
REQ-032 Sub-module chunk_adder SHALL be a combinational CHUNK_W-bit ripple adder built from full-adder cells (ports a, b, cin, sum, cout).
REQ-033 Leading-one detection and the FSM SHALL reside in dyn_chunk_adder.

Verification (defaults, macro defined unless noted)
REQ-034 a=0xFF, b=0x0FF -> sum=0x1FE, eff_w=8, out_valid 2 cycles after accept.
REQ-035 a=0x01, b=0x3FF -> sum=0x400, eff_w=10, out_valid 3 cycles after accept.
REQ-036 a=0x80, b=0x100 -> sum=0x180, eff_w=9, 3 cycles; a=0, b=0 -> sum=0, eff_w=8.
REQ-037 out_ready=0 for 5 cycles in DONE -> out_valid, sum and eff_w stable, in_ready=0 throughout; in_ready=1 on the cycle after handshake.
REQ-038 rst_n pulsed low during CALC -> all outputs 0 and in_ready=1 at once; the next transaction completes correctly.
REQ-039 Macro undefined, a=0xFF, b=0x0FF -> sum=0x1FE, eff_w=8, 3 cycles.
